// File: rtl/apb_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_req_arbiter: round-robin sharing of one APB master between requesters, |
// | with SETUP/ACCESS sequencing and an ACCESS timeout.   Rev 1.0              |
// +----------------------------------------------------------------------------+
module apb_req_arbiter #(
   parameter int NB_REQ         = 4,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NB_REQ-1:0]                  req_i,
   input  logic [NB_REQ-1:0]                  we_i,
   input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   addr_i,
   input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   wdata_i,
   output logic [NB_REQ-1:0]                  gnt_o,
   output logic [NB_REQ-1:0]                  rvalid_o,
   output logic [APB_DATA_WIDTH-1:0]          rdata_o,
   output logic                               err_o,
   output logic                               psel_o,
   output logic                               penable_o,
   output logic                               pwrite_o,
   output logic [APB_ADDR_WIDTH-1:0]          paddr_o,
   output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
   input  logic [APB_DATA_WIDTH-1:0]          prdata_i,
   input  logic                               pready_i,
   input  logic                               pslverr_i
);

   localparam int              IW             = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
   localparam logic [IW-1:0]   c_last_rst     = IW'(NB_REQ - 1);
   localparam logic [15:0]     c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [IW-1:0] r_owner;
   logic [IW-1:0] r_last;
   logic [15:0]   r_cnt;
   logic [IW-1:0] w_cand;
   logic [IW-1:0] w_win;
   logic          w_any;
   logic          w_done;
   logic          w_timeout;

   // Walk candidates from farthest to nearest so the nearest requester after
   // the previous winner is the last assignment and therefore wins.
   always_comb begin
      w_any  = 1'b0;
      w_win  = '0;
      w_cand = '0;
      for (int i = NB_REQ; i >= 1; i--) begin
         w_cand = IW'((32'(r_last) + 32'(i)) % 32'(NB_REQ));
         if (req_i[w_cand]) begin
            w_any = 1'b1;
            w_win = w_cand;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_done    = 1'b0;
      w_timeout = 1'b0;
      psel_o    = 1'b0;
      penable_o = 1'b0;
      gnt_o     = '0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_next = SETUP;
            end
         end
         SETUP: begin
            psel_o         = 1'b1;
            gnt_o[r_owner] = 1'b1;
            w_next         = ACCESS;
         end
         ACCESS: begin
            psel_o    = 1'b1;
            penable_o = 1'b1;
            // A ready slave takes precedence over an expiring timeout.
            if (pready_i) begin
               w_done = 1'b1;
               w_next = IDLE;
            end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == c_timeout_last)) begin
               w_done    = 1'b1;
               w_timeout = 1'b1;
               w_next    = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_owner  <= '0;
         r_last   <= c_last_rst;
         r_cnt    <= '0;
         pwrite_o <= 1'b0;
         paddr_o  <= '0;
         pwdata_o <= '0;
         rdata_o  <= '0;
         err_o    <= 1'b0;
         rvalid_o <= '0;
      end else begin
         rvalid_o <= '0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_owner  <= w_win;
                  r_last   <= w_win;
                  pwrite_o <= we_i[w_win];
                  paddr_o  <= addr_i[w_win*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                  pwdata_o <= wdata_i[w_win*APB_DATA_WIDTH +: APB_DATA_WIDTH];
               end
            end
            SETUP: begin
               r_cnt <= '0;
            end
            ACCESS: begin
               if (w_done) begin
                  rvalid_o[r_owner] <= 1'b1;
                  rdata_o           <= w_timeout ? '0 : prdata_i;
                  err_o             <= w_timeout | pslverr_i;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_apb_req_arbiter: scoreboard bench for apb_req_arbiter.   Rev 1.0        |
// +----------------------------------------------------------------------------+
module tb_apb_req_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [N-1:0]    req, we, gnt, rvalid;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [DW-1:0]   rdata, pwdata, prdata;
   logic [AW-1:0]   paddr;
   logic            err, psel, penable, pwrite, pready, pslverr;

   logic [N-1:0]    req_z, we_z, gnt_z, rvalid_z;
   logic [N*AW-1:0] addr_z;
   logic [N*DW-1:0] wdata_z;
   logic [DW-1:0]   rdata_z, pwdata_z, prdata_z;
   logic [AW-1:0]   paddr_z;
   logic            err_z, psel_z, penable_z, pwrite_z, pready_z, pslverr_z;

   apb_req_arbiter #(.NB_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
      .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr), .pwdata_o(pwdata),
      .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
   );

   apb_req_arbiter #(.NB_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut_z (
      .clk_i(clk), .rst_i(rst), .req_i(req_z), .we_i(we_z), .addr_i(addr_z), .wdata_i(wdata_z),
      .gnt_o(gnt_z), .rvalid_o(rvalid_z), .rdata_o(rdata_z), .err_o(err_z),
      .psel_o(psel_z), .penable_o(penable_z), .pwrite_o(pwrite_z), .paddr_o(paddr_z), .pwdata_o(pwdata_z),
      .prdata_i(prdata_z), .pready_i(pready_z), .pslverr_i(pslverr_z)
   );

   typedef struct packed {
      logic [N-1:0]  onehot;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          we;
   } gexp_t;

   typedef struct packed {
      logic [N-1:0]  onehot;
      logic [DW-1:0] rdata;
      logic          err;
   } cexp_t;

   gexp_t gq[$];
   cexp_t cq[$];
   gexp_t ge;
   cexp_t ce;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_gnt(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
      gexp_t g;
      g.onehot = N'(1 << k);
      g.addr   = a;
      g.wdata  = d;
      g.we     = w;
      gq.push_back(g);
   endtask

   task automatic push_cpl(input int k, input logic [DW-1:0] rd, input logic e);
      cexp_t c;
      c.onehot = N'(1 << k);
      c.rdata  = rd;
      c.err    = e;
      cq.push_back(c);
   endtask

   // Scoreboard monitor: every grant and completion pulse pops one expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (gnt != '0) begin
            if (gq.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_gnt: got %b, expected no grant", gnt);
            end else begin
               ge = gq.pop_front();
               check("gnt_onehot", 64'(gnt), 64'(ge.onehot));
               check("paddr", 64'(paddr), 64'(ge.addr));
               check("pwdata", 64'(pwdata), 64'(ge.wdata));
               check("pwrite", 64'(pwrite), 64'(ge.we));
            end
         end
         if (rvalid != '0) begin
            if (cq.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_rvalid: got %b, expected no completion", rvalid);
            end else begin
               ce = cq.pop_front();
               check("rvalid_onehot", 64'(rvalid), 64'(ce.onehot));
               check("rdata", 64'(rdata), 64'(ce.rdata));
               check("err", 64'(err), 64'(ce.err));
            end
         end
      end
   end

   task automatic wait_gnt(output int lat);
      lat = -1;
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         if (gnt != '0) begin
            lat = c;
            return;
         end
      end
   endtask

   // One transfer on requester k; exp_access is the required number of ACCESS cycles.
   task automatic do_xfer(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int waits, input logic [DW-1:0] rd, input logic se,
                          input logic stuck, input int exp_access);
      int lat;
      int n;
      @(posedge clk); #1;
      req = '0;
      req[k] = 1'b1;
      we[k] = w;
      addr[k*AW +: AW] = a;
      wdata[k*DW +: DW] = d;
      prdata = rd;
      pslverr = se;
      pready = 1'b0;
      push_gnt(k, a, d, w);
      push_cpl(k, stuck ? '0 : rd, stuck ? 1'b1 : se);
      wait_gnt(lat);
      check("grant_latency", 64'(lat), 64'(1));
      if (lat < 0) begin
         req = '0;
         return;
      end
      check("setup_psel_penable", 64'({psel, penable}), 64'(2'b10));
      @(posedge clk); #1;
      req[k] = 1'b0;
      n = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (!(psel && penable)) break;
         n++;
         if (!stuck && n == waits + 1) pready = 1'b1;
      end
      pready = 1'b0;
      check("access_cycles", 64'(n), 64'(exp_access));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, gap, cnt, rv;
      bit seen;
      int order [6] = '{0, 1, 3, 0, 1, 3};

      rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
      prdata = '0; pready = 1'b0; pslverr = 1'b0;
      req_z = '0; we_z = '0; addr_z = '0; wdata_z = '0;
      prdata_z = '0; pready_z = 1'b0; pslverr_z = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_gnt", 64'(gnt), 64'(0));
      check("rst_rvalid", 64'(rvalid), 64'(0));
      check("rst_psel", 64'(psel), 64'(0));
      check("rst_penable", 64'(penable), 64'(0));
      check("rst_pwrite", 64'(pwrite), 64'(0));
      check("rst_paddr", 64'(paddr), 64'(0));
      check("rst_pwdata", 64'(pwdata), 64'(0));
      check("rst_rdata", 64'(rdata), 64'(0));
      check("rst_err", 64'(err), 64'(0));

      // single write, then a read with three wait states
      do_xfer(2, 1'b1, 32'h1A10_0004, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 1'b0, 1);
      do_xfer(1, 1'b0, 32'h0000_0100, 32'h0, 3, 32'h1234_5678, 1'b0, 1'b0, 4);

      // round robin from reset with 4'b1011 held
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      prdata = 32'h0000_00A5; pslverr = 1'b0; pready = 1'b1; we = 4'b1010;
      for (int k = 0; k < N; k++) begin
         addr[k*AW +: AW]  = 32'h4000_0000 + 32'(k * 16);
         wdata[k*DW +: DW] = 32'h0000_1000 + 32'(k);
      end
      for (int g = 0; g < 6; g++) begin
         push_gnt(order[g], 32'h4000_0000 + 32'(order[g] * 16), 32'h0000_1000 + 32'(order[g]), we[order[g]]);
         push_cpl(order[g], 32'h0000_00A5, 1'b0);
      end
      req = 4'b1011;
      for (int g = 0; g < 6; g++) begin
         seen = 1'b0;
         gap = 0;
         for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
               seen = 1'b1;
               gap = c;
               break;
            end
         end
         check("rr_spacing", 64'(gap), (g == 0) ? 64'(2) : 64'(3));
         if (!seen) break;
         if (g == 5) req = '0;
      end
      req = '0;
      repeat (3) @(negedge clk);
      pready = 1'b0;

      // ACCESS timeout and slave error handling
      do_xfer(3, 1'b0, 32'h2000_0000, 32'h0, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 8);
      do_xfer(0, 1'b0, 32'h3000_0008, 32'h0, 0, 32'hBAD0_0001, 1'b1, 1'b0, 1);
      do_xfer(2, 1'b1, 32'h3000_000C, 32'hCAFE_F00D, 1, 32'h0000_0055, 1'b0, 1'b0, 2);

      // reset during a wait state aborts the transfer without a completion
      @(posedge clk); #1;
      req = 4'b1000; we = '0; addr[3*AW +: AW] = 32'h5000_0010; wdata[3*DW +: DW] = 32'h0;
      prdata = 32'h0000_0077; pslverr = 1'b0; pready = 1'b0;
      push_gnt(3, 32'h5000_0010, 32'h0, 1'b0);
      wait_gnt(lat);
      check("abort_grant_latency", 64'(lat), 64'(1));
      @(posedge clk); #1 req = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1; req = 4'b1111;
      @(posedge clk); #1 rst = 1'b0;
      check("abort_gnt", 64'(gnt), 64'(0));
      check("abort_rvalid", 64'(rvalid), 64'(0));
      check("abort_psel", 64'(psel), 64'(0));
      check("abort_penable", 64'(penable), 64'(0));
      check("abort_pwrite", 64'(pwrite), 64'(0));
      check("abort_paddr", 64'(paddr), 64'(0));
      check("abort_pwdata", 64'(pwdata), 64'(0));
      check("abort_rdata", 64'(rdata), 64'(0));
      check("abort_err", 64'(err), 64'(0));
      pready = 1'b1;
      push_gnt(0, addr[0 +: AW], wdata[0 +: DW], we[0]);
      push_cpl(0, 32'h0000_0077, 1'b0);
      wait_gnt(lat);
      check("post_reset_grant_latency", 64'(lat), 64'(1));
      @(posedge clk); #1 req = '0;
      repeat (3) @(negedge clk);
      pready = 1'b0;

      // timeout disabled: ACCESS must persist
      @(posedge clk); #1;
      req_z = 4'b0001; we_z = 4'b0001; addr_z[0 +: AW] = 32'h6000_0000;
      seen = 1'b0;
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         if (gnt_z != '0) begin
            seen = 1'b1;
            break;
         end
      end
      check("nto_gnt_seen", 64'(seen), 64'(1));
      @(posedge clk); #1 req_z = '0;
      cnt = 0;
      rv = 0;
      repeat (1000) begin
         @(negedge clk);
         if (psel_z && penable_z) cnt++;
         if (rvalid_z != '0) rv++;
      end
      check("nto_access_cycles", 64'(cnt), 64'(1000));
      check("nto_rvalid_count", 64'(rv), 64'(0));

      repeat (3) @(negedge clk);
      check("gnt_queue_drained", 64'(gq.size()), 64'(0));
      check("cpl_queue_drained", 64'(cq.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
